sp_stack_ctrl: RTL and testbench
================================

Name: sp_stack_ctrl

Overview:
- Parametrised stack-pointer controller; next generation of the CPU's fixed 5-bit SP register.
- Tracks stack occupancy under push/pop/load commands from the decode/execute stage.
- Generates SP, write (push) and read (pop) addresses for the stack memory, full/empty status and sticky overflow/underflow error flags.
- Sits between the pipeline control logic and the stack RAM.

Parameters:
- SP_W, 5, width of SP and address outputs.
- DEPTH, 32, stack capacity in entries; 1 <= DEPTH <= 2^SP_W.
- BASE, 0, SP value when the stack is empty.
- GROW_DOWN, 0, 0: SP increments on push; 1: SP decrements on push.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- push  in  1  push request this cycle.
- pop  in  1  pop request this cycle.
- load  in  1  load occupancy count from ld_cnt.
- ld_cnt  in  SP_W+1  new occupancy count, valid range 0..DEPTH.
- clr_err  in  1  clear sticky error flags.
- sp  out  SP_W  current stack pointer (next free slot).
- wr_addr  out  SP_W  address a push writes this cycle (= sp).
- rd_addr  out  SP_W  top-of-stack address: sp-1 if GROW_DOWN=0, sp+1 if GROW_DOWN=1 (mod 2^SP_W).
- count  out  SP_W+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf  out  1  sticky overflow / illegal-load flag.
- unf  out  1  sticky underflow flag.

Behaviour:
- Single state register cnt (SP_W+1 bits), plus ovf and unf flops. All outputs are registered or decoded combinationally from these flops only; there is no input-to-output combinational path.
- sp = BASE + cnt (GROW_DOWN=0) or BASE - cnt (GROW_DOWN=1), truncated to SP_W bits (wrap modulo 2^SP_W).
- Reset (rst=1 at posedge): cnt=0, ovf=0, unf=0. Outputs next cycle: sp=BASE, empty=1, full=0. rst overrides all other inputs, including mid-operation commands.
- Command priority per posedge, after rst: load > push/pop.
- load=1, ld_cnt <= DEPTH: cnt=ld_cnt. push and pop are ignored that cycle.
- load=1, ld_cnt > DEPTH: cnt unchanged, ovf set.
- push=1, pop=1 together: cnt unchanged (top replaced), no flag change, including when full or empty.
  - Consumer writes at rd_addr when non-empty.
  - When empty, the pair is a no-op.
- push only, not full: cnt = cnt+1.
- push only, full: cnt unchanged, ovf set.
- pop only, not empty: cnt = cnt-1.
- pop only, empty: cnt unchanged, unf set.
- Latency: every command takes effect on the next posedge; sp/count/full/empty update 1 cycle after the command edge.
- wr_addr and rd_addr reflect the pre-edge cnt, so a push in cycle N writes wr_addr of cycle N.
- clr_err=1: ovf=0 and unf=0 at the edge. An error event in the same cycle wins, so the flag stays/becomes 1.
- Flags are sticky until clr_err or rst.
- DEPTH = 2^SP_W: full state gives sp == BASE (wrapped); full/empty are disambiguated by count, never by sp.
- Debug: at each negedge, simulation-only display of "SP = %d" and count, excluded from synthesis.

Test Plan:
- Reset then idle (defaults) -> sp=0, count=0, empty=1, full=0, ovf=unf=0; rd_addr=31.
- 32 consecutive pushes (defaults) -> sp counts 1..31 then wraps to 0; count=32, full=1. 33rd push -> count stays 32, ovf=1.
- From empty, pop -> unf=1, sp=0. Then clr_err together with another pop -> unf remains 1. clr_err alone -> unf=0.
- GROW_DOWN=1, BASE=31, DEPTH=16: 3 pushes -> sp=28, wr_addr sequence 31,30,29, rd_addr=29. Pop -> sp=29.
- Simultaneous push+pop at count=5 -> count stays 5, sp unchanged. load with ld_cnt=40 (>32) -> count unchanged, ovf=1. load ld_cnt=10 with push=1 -> count=10.
- rst asserted mid-burst at count=7 with push=1 -> next cycle count=0, sp=BASE, flags cleared.

Source files
------------

// File: rtl/sp_stack_ctrl.sv
// Parametrised stack-pointer controller: tracks occupancy under push/pop/load
// and decodes SP, write/read addresses, full/empty and sticky error flags.
module sp_stack_ctrl #(
  parameter int unsigned SP_W      = 5,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned BASE      = 0,
  parameter int unsigned GROW_DOWN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            load,
  input  logic [SP_W:0]   ld_cnt,
  input  logic            clr_err,
  output logic [SP_W-1:0] sp,
  output logic [SP_W-1:0] wr_addr,
  output logic [SP_W-1:0] rd_addr,
  output logic [SP_W:0]   count,
  output logic            full,
  output logic            empty,
  output logic            ovf,
  output logic            unf
);

  localparam logic [SP_W:0]   DEPTH_C = (SP_W+1)'(DEPTH);
  localparam logic [SP_W-1:0] BASE_C  = SP_W'(BASE);
  localparam logic [SP_W-1:0] ONE_SP  = SP_W'(1);
  localparam logic [SP_W:0]   ONE_CNT = (SP_W+1)'(1);

  logic [SP_W:0] cnt;
  logic [SP_W:0] cnt_nxt;
  logic          ovf_set;
  logic          unf_set;

  // Occupancy is the only state; full/empty come from cnt, never from sp,
  // because sp wraps back to BASE when DEPTH == 2^SP_W.
  always_comb begin
    count   = cnt;
    full    = (cnt == DEPTH_C);
    empty   = (cnt == '0);
    sp      = (GROW_DOWN != 0) ? (BASE_C - cnt[SP_W-1:0]) : (BASE_C + cnt[SP_W-1:0]);
    wr_addr = sp;
    rd_addr = (GROW_DOWN != 0) ? (sp + ONE_SP) : (sp - ONE_SP);
  end

  // Load beats push/pop; a simultaneous push+pop only replaces the top entry.
  always_comb begin
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (load) begin
      if (ld_cnt <= DEPTH_C) cnt_nxt = ld_cnt;
      else                   ovf_set = 1'b1;
    end else if (push && !pop) begin
      if (full) ovf_set = 1'b1;
      else      cnt_nxt = cnt + ONE_CNT;
    end else if (pop && !push) begin
      if (empty) unf_set = 1'b1;
      else       cnt_nxt = cnt - ONE_CNT;
    end
  end

  // A same-cycle error event wins over clr_err so no error is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf_set | (ovf & ~clr_err);
      unf <= unf_set | (unf & ~clr_err);
    end
  end

endmodule

// File: tb/tb_sp_stack_ctrl.sv
// Directed bench for sp_stack_ctrl: default (grow-up, 32 deep) instance and a
// grow-down instance with BASE=31, DEPTH=16.
module tb_sp_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       push_a = 0, pop_a = 0, load_a = 0, clr_a = 0;
  logic [5:0] ldc_a = '0;
  logic [4:0] sp_a, wr_a, rd_a;
  logic [5:0] cnt_a;
  logic       full_a, empty_a, ovf_a, unf_a;

  logic       push_b = 0, pop_b = 0, load_b = 0, clr_b = 0;
  logic [5:0] ldc_b = '0;
  logic [4:0] sp_b, wr_b, rd_b;
  logic [5:0] cnt_b;
  logic       full_b, empty_b, ovf_b, unf_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sp_stack_ctrl dut_a (
    .clk(clk), .rst(rst), .push(push_a), .pop(pop_a), .load(load_a),
    .ld_cnt(ldc_a), .clr_err(clr_a), .sp(sp_a), .wr_addr(wr_a),
    .rd_addr(rd_a), .count(cnt_a), .full(full_a), .empty(empty_a),
    .ovf(ovf_a), .unf(unf_a)
  );

  sp_stack_ctrl #(.SP_W(5), .DEPTH(16), .BASE(31), .GROW_DOWN(1)) dut_b (
    .clk(clk), .rst(rst), .push(push_b), .pop(pop_b), .load(load_b),
    .ld_cnt(ldc_b), .clr_err(clr_b), .sp(sp_b), .wr_addr(wr_b),
    .rd_addr(rd_b), .count(cnt_b), .full(full_b), .empty(empty_b),
    .ovf(ovf_b), .unf(unf_b)
  );

  // Debug trace of the default instance's stack pointer
  always @(negedge clk) $display("[TB] SP = %0d count = %0d", sp_a, cnt_a);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one command cycle to instance a (down=0) or b (down=1), sample #1 after the edge
  task automatic applyStimulus(input bit down, input logic ps, input logic pp, input logic ld,
                               input logic [5:0] lc, input logic ce, input logic rs);
    @(negedge clk);
    if (down) begin
      push_b = ps; pop_b = pp; load_b = ld; ldc_b = lc; clr_b = ce;
    end else begin
      push_a = ps; pop_a = pp; load_a = ld; ldc_a = lc; clr_a = ce;
    end
    rst = rs;
    @(posedge clk);
    #1;
    push_a = 0; pop_a = 0; load_a = 0; ldc_a = '0; clr_a = 0;
    push_b = 0; pop_b = 0; load_b = 0; ldc_b = '0; clr_b = 0;
    rst = 0;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 6'd0, 0, 1);
    applyStimulus(0, 0, 0, 0, 6'd0, 0, 0);

    // Grow-down instance
    checkOutput("b_rst_sp", sp_b, 31);
    checkOutput("b_rst_rd", rd_b, 0);
    checkOutput("b_wr0", wr_b, 31);
    applyStimulus(1, 1, 0, 0, 6'd0, 0, 0);
    checkOutput("b_wr1", wr_b, 30);
    applyStimulus(1, 1, 0, 0, 6'd0, 0, 0);
    checkOutput("b_wr2", wr_b, 29);
    applyStimulus(1, 1, 0, 0, 6'd0, 0, 0);
    checkOutput("b_sp3", sp_b, 28);
    checkOutput("b_rd3", rd_b, 29);
    checkOutput("b_cnt3", cnt_b, 3);
    applyStimulus(1, 0, 1, 0, 6'd0, 0, 0);
    checkOutput("b_pop_sp", sp_b, 29);
    checkOutput("b_pop_cnt", cnt_b, 2);
    applyStimulus(1, 0, 0, 1, 6'd16, 0, 0);
    checkOutput("b_ld16_full", full_b, 1);
    checkOutput("b_ld16_sp", sp_b, 15);
    applyStimulus(1, 1, 0, 0, 6'd0, 0, 0);
    checkOutput("b_push_full_ovf", ovf_b, 1);
    checkOutput("b_push_full_cnt", cnt_b, 16);
    applyStimulus(1, 0, 0, 1, 6'd17, 1, 0);
    checkOutput("b_ld17_clr_ovf", ovf_b, 1);
    checkOutput("b_ld17_cnt", cnt_b, 16);

    // Default instance: reset state
    checkOutput("a_rst_sp", sp_a, 0);
    checkOutput("a_rst_cnt", cnt_a, 0);
    checkOutput("a_rst_empty", empty_a, 1);
    checkOutput("a_rst_full", full_a, 0);
    checkOutput("a_rst_ovf", ovf_a, 0);
    checkOutput("a_rst_unf", unf_a, 0);
    checkOutput("a_rst_rd", rd_a, 31);

    // Underflow and clear priority
    applyStimulus(0, 0, 1, 0, 6'd0, 0, 0);
    checkOutput("a_unf_set", unf_a, 1);
    checkOutput("a_unf_sp", sp_a, 0);
    applyStimulus(0, 0, 1, 0, 6'd0, 1, 0);
    checkOutput("a_unf_clr_pop", unf_a, 1);
    applyStimulus(0, 0, 0, 0, 6'd0, 1, 0);
    checkOutput("a_unf_clr", unf_a, 0);

    // Fill to capacity
    for (int i = 0; i < 32; i++) begin
      checkOutput("a_fill_wr", wr_a, i);
      applyStimulus(0, 1, 0, 0, 6'd0, 0, 0);
      checkOutput("a_fill_sp", sp_a, (i + 1) % 32);
    end
    checkOutput("a_full_cnt", cnt_a, 32);
    checkOutput("a_full_flag", full_a, 1);
    checkOutput("a_full_empty", empty_a, 0);
    checkOutput("a_full_rd", rd_a, 31);
    applyStimulus(0, 1, 0, 0, 6'd0, 0, 0);
    checkOutput("a_ovf_cnt", cnt_a, 32);
    checkOutput("a_ovf_set", ovf_a, 1);
    applyStimulus(0, 1, 1, 0, 6'd0, 0, 0);
    checkOutput("a_pp_full_cnt", cnt_a, 32);
    applyStimulus(0, 0, 0, 0, 6'd0, 1, 0);
    checkOutput("a_ovf_clr", ovf_a, 0);

    // Loads and simultaneous push+pop
    applyStimulus(0, 0, 0, 1, 6'd5, 0, 0);
    checkOutput("a_ld5_cnt", cnt_a, 5);
    applyStimulus(0, 1, 1, 0, 6'd0, 0, 0);
    checkOutput("a_pp_cnt", cnt_a, 5);
    checkOutput("a_pp_sp", sp_a, 5);
    checkOutput("a_pp_ovf", ovf_a, 0);
    applyStimulus(0, 0, 0, 1, 6'd40, 0, 0);
    checkOutput("a_ld40_cnt", cnt_a, 5);
    checkOutput("a_ld40_ovf", ovf_a, 1);
    applyStimulus(0, 1, 0, 1, 6'd10, 0, 0);
    checkOutput("a_ld10_cnt", cnt_a, 10);
    checkOutput("a_ld10_sp", sp_a, 10);
    applyStimulus(0, 0, 1, 0, 6'd0, 0, 0);
    checkOutput("a_pop_cnt", cnt_a, 9);
    checkOutput("a_pop_rd", rd_a, 8);

    // Reset mid-burst overrides push
    applyStimulus(0, 0, 0, 1, 6'd7, 0, 0);
    checkOutput("a_ld7_cnt", cnt_a, 7);
    applyStimulus(0, 1, 0, 0, 6'd0, 0, 1);
    checkOutput("a_mrst_cnt", cnt_a, 0);
    checkOutput("a_mrst_sp", sp_a, 0);
    checkOutput("a_mrst_ovf", ovf_a, 0);
    checkOutput("a_mrst_empty", empty_a, 1);

    // Push+pop on empty is a no-op
    applyStimulus(0, 1, 1, 0, 6'd0, 0, 0);
    checkOutput("a_pp_empty_cnt", cnt_a, 0);
    checkOutput("a_pp_empty_unf", unf_a, 0);
    checkOutput("a_pp_empty_ovf", ovf_a, 0);

    // Boundary load of exactly DEPTH is legal
    applyStimulus(0, 0, 0, 1, 6'd32, 0, 0);
    checkOutput("a_ld32_cnt", cnt_a, 32);
    checkOutput("a_ld32_full", full_a, 1);
    checkOutput("a_ld32_ovf", ovf_a, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
